// File: rtl/spi_frame_pkg.sv
// Shared definitions for the UART-to-SPI frame controller: header layout,
// queued-frame header record and the state encodings of both FSMs.
package spi_frame_pkg;

  localparam int RW_BIT   = 7;
  localparam int CFG_BIT  = 6;
  localparam int ADDR_MSB = 5;

  // Header half of a queued frame; the payload is appended by the top
  // because its width follows DATA_BYTES.
  typedef struct packed {
    logic                cfg;
    logic                rw;
    logic [ADDR_MSB:0]   addr;
  } frame_hdr_t;

  typedef enum logic [1:0] {
    ASM_HDR,
    ASM_DATA,
    ASM_PUSH
  } asm_state_e;

  typedef enum logic [2:0] {
    ISS_IDLE,
    ISS_LOAD,
    ISS_START,
    ISS_WAIT_BUSY,
    ISS_WAIT_DONE,
    ISS_RET
  } iss_state_e;

  typedef enum logic [1:0] {
    RET_SEND,
    RET_WAIT_HI,
    RET_WAIT_LO
  } ret_phase_e;

  function automatic frame_hdr_t decode_hdr(input logic [7:0] b);
    frame_hdr_t h;
    h.cfg  = b[CFG_BIT];
    h.rw   = b[RW_BIT];
    h.addr = b[ADDR_MSB:0];
    return h;
  endfunction

endpackage

// File: rtl/spi_frame_fifo.sv
// Synchronous FIFO with registered occupancy count and registered read port,
// so the storage maps onto block RAM.
module spi_frame_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = rd_data_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage and read register carry no reset so they stay RAM-inferable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
    if (do_pop)  rd_data_q <= mem[rd_ptr_q];
  end

endmodule

// File: rtl/spi_frame_ctrl.sv
// UART-to-SPI command controller: assembles header+payload frames, queues
// them, runs one SPI transaction per frame and returns read words over UART.
module spi_frame_ctrl
  import spi_frame_pkg::*;
#(
  parameter int          DATA_BYTES  = 2,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          TIMEOUT     = 150000,
  parameter logic [31:0] CLK_DIV_RST = 32'd1
) (
  input  logic                    clk_150MHz_i,
  input  logic                    reset,
  input  logic [7:0]              rx_uart_data,
  input  logic                    rx_ready,
  input  logic                    busy,
  input  logic [8*DATA_BYTES-1:0] spi_rx_data,
  input  logic                    tx_uart_busy,
  output logic [31:0]             clk_div,
  output logic [31:0]             addr,
  output logic [8*DATA_BYTES-1:0] tx_data,
  output logic                    rw,
  output logic                    enable,
  output logic [7:0]              tx_uart_data,
  output logic                    tx_uart_start,
  output logic                    fifo_full,
  output logic                    frame_err
);

  localparam int DW  = 8 * DATA_BYTES;
  localparam int EW  = $bits(frame_hdr_t) + DW;
  localparam int BCW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int GW  = $clog2(TIMEOUT + 1);

  // ---------------- frame assembler ----------------
  asm_state_e     asm_q, asm_d;
  frame_hdr_t     hdr_q, hdr_d;
  logic [DW-1:0]  pay_q, pay_d;
  logic [BCW-1:0] acnt_q, acnt_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           frame_err_q, frame_err_d;
  logic           fifo_push, fifo_pop, fifo_empty;
  logic [EW-1:0]  fifo_rd_data;

  always_comb begin
    asm_d       = asm_q;
    hdr_d       = hdr_q;
    pay_d       = pay_q;
    acnt_d      = acnt_q;
    gap_d       = gap_q;
    fifo_push   = 1'b0;
    frame_err_d = 1'b0;
    case (asm_q)
      ASM_HDR: begin
        if (rx_ready) begin
          hdr_d  = decode_hdr(rx_uart_data);
          acnt_d = '0;
          gap_d  = '0;
          asm_d  = ASM_DATA;
        end
      end
      ASM_DATA: begin
        if (rx_ready) begin
          pay_d = (pay_q << 8) | DW'(rx_uart_data);
          gap_d = '0;
          if (acnt_q == BCW'(DATA_BYTES - 1)) asm_d = ASM_PUSH;
          else acnt_d = acnt_q + 1'b1;
        end else if (gap_q == GW'(TIMEOUT - 1)) begin
          frame_err_d = 1'b1;
          asm_d       = ASM_HDR;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ASM_PUSH: begin
        // Full is the registered flag: a pop in this same cycle does not help.
        fifo_push   = !fifo_full;
        frame_err_d = fifo_full;
        if (rx_ready) begin
          hdr_d  = decode_hdr(rx_uart_data);
          acnt_d = '0;
          gap_d  = '0;
          asm_d  = ASM_DATA;
        end else begin
          asm_d = ASM_HDR;
        end
      end
      default: asm_d = ASM_HDR;
    endcase
  end

  always_ff @(posedge clk_150MHz_i) begin
    if (reset) begin
      asm_q       <= ASM_HDR;
      hdr_q       <= '0;
      pay_q       <= '0;
      acnt_q      <= '0;
      gap_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      hdr_q       <= hdr_d;
      pay_q       <= pay_d;
      acnt_q      <= acnt_d;
      gap_q       <= gap_d;
      frame_err_q <= frame_err_d;
    end
  end

  spi_frame_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_150MHz_i),
    .srst    (reset),
    .push    (fifo_push),
    .wr_data ({hdr_q, pay_q}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ---------------- issue FSM ----------------
  frame_hdr_t     f_hdr;
  logic [DW-1:0]  f_data;
  iss_state_e     iss_q, iss_d;
  ret_phase_e     phase_q, phase_d;
  logic [31:0]    clk_div_q, clk_div_d;
  logic [31:0]    addr_q, addr_d;
  logic [DW-1:0]  tx_data_q, tx_data_d;
  logic           rw_q, rw_d;
  logic [DW-1:0]  ret_word_q, ret_word_d;
  logic [BCW-1:0] rbyte_q, rbyte_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic           tx_start_q, tx_start_d;

  assign {f_hdr, f_data} = fifo_rd_data;

  always_comb begin
    iss_d      = iss_q;
    phase_d    = phase_q;
    clk_div_d  = clk_div_q;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    rw_d       = rw_q;
    ret_word_d = ret_word_q;
    rbyte_d    = rbyte_q;
    tx_byte_d  = tx_byte_q;
    tx_start_d = 1'b0;
    fifo_pop   = 1'b0;
    case (iss_q)
      ISS_IDLE: begin
        if (!fifo_empty && !busy) begin
          fifo_pop = 1'b1;
          iss_d    = ISS_LOAD;
        end
      end
      ISS_LOAD: begin
        if (f_hdr.cfg) begin
          clk_div_d = 32'(f_data);
          iss_d     = ISS_IDLE;
        end else begin
          addr_d    = {{(31 - ADDR_MSB){1'b0}}, f_hdr.addr};
          tx_data_d = f_data;
          rw_d      = f_hdr.rw;
          iss_d     = ISS_START;
        end
      end
      ISS_START: iss_d = ISS_WAIT_BUSY;
      ISS_WAIT_BUSY: begin
        if (busy) iss_d = ISS_WAIT_DONE;
      end
      ISS_WAIT_DONE: begin
        if (!busy) begin
          if (rw_q) begin
            ret_word_d = spi_rx_data;
            rbyte_d    = '0;
            phase_d    = RET_SEND;
            iss_d      = ISS_RET;
          end else begin
            iss_d = ISS_IDLE;
          end
        end
      end
      ISS_RET: begin
        // Full UART handshake per byte: strobe, see busy rise, see it fall.
        case (phase_q)
          RET_SEND: begin
            if (!tx_uart_busy) begin
              tx_start_d = 1'b1;
              tx_byte_d  = ret_word_q[DW-1 -: 8];
              ret_word_d = ret_word_q << 8;
              phase_d    = RET_WAIT_HI;
            end
          end
          RET_WAIT_HI: begin
            if (tx_uart_busy) phase_d = RET_WAIT_LO;
          end
          RET_WAIT_LO: begin
            if (!tx_uart_busy) begin
              phase_d = RET_SEND;
              if (rbyte_q == BCW'(DATA_BYTES - 1)) iss_d = ISS_IDLE;
              else rbyte_d = rbyte_q + 1'b1;
            end
          end
          default: phase_d = RET_SEND;
        endcase
      end
      default: iss_d = ISS_IDLE;
    endcase
  end

  always_ff @(posedge clk_150MHz_i) begin
    if (reset) begin
      iss_q      <= ISS_IDLE;
      phase_q    <= RET_SEND;
      clk_div_q  <= CLK_DIV_RST;
      addr_q     <= '0;
      tx_data_q  <= '0;
      rw_q       <= 1'b0;
      ret_word_q <= '0;
      rbyte_q    <= '0;
      tx_byte_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      iss_q      <= iss_d;
      phase_q    <= phase_d;
      clk_div_q  <= clk_div_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      rw_q       <= rw_d;
      ret_word_q <= ret_word_d;
      rbyte_q    <= rbyte_d;
      tx_byte_q  <= tx_byte_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign clk_div       = clk_div_q;
  assign addr          = addr_q;
  assign tx_data       = tx_data_q;
  assign rw            = rw_q;
  assign enable        = (iss_q == ISS_START);
  assign tx_uart_data  = tx_byte_q;
  assign tx_uart_start = tx_start_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl: directed frames, an in-order
// transaction/byte scoreboard, and simple SPI master and UART TX models.
`timescale 1ns/1ps
module tb_spi_frame_ctrl;

  localparam int DATA_BYTES = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 40;
  localparam int DW         = 8 * DATA_BYTES;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_uart_data = '0;
  logic          rx_ready = 1'b0;
  logic          busy;
  logic          model_busy = 1'b0;
  logic          hold_busy = 1'b0;
  logic [DW-1:0] spi_rx_data = '0;
  logic          tx_uart_busy = 1'b0;
  logic [31:0]   clk_div, addr;
  logic [DW-1:0] tx_data;
  logic          rw, enable, tx_uart_start, fifo_full, frame_err;
  logic [7:0]    tx_uart_data;

  assign busy = model_busy | hold_busy;

  spi_frame_ctrl #(
    .DATA_BYTES  (DATA_BYTES),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT     (TIMEOUT),
    .CLK_DIV_RST (32'd1)
  ) dut (
    .clk_150MHz_i  (clk),
    .reset         (reset),
    .rx_uart_data  (rx_uart_data),
    .rx_ready      (rx_ready),
    .busy          (busy),
    .spi_rx_data   (spi_rx_data),
    .tx_uart_busy  (tx_uart_busy),
    .clk_div       (clk_div),
    .addr          (addr),
    .tx_data       (tx_data),
    .rw            (rw),
    .enable        (enable),
    .tx_uart_data  (tx_uart_data),
    .tx_uart_start (tx_uart_start),
    .fifo_full     (fifo_full),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   addr;
    logic [DW-1:0] data;
    logic          rw;
    logic [31:0]   div;
  } txn_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          en_count = 0, start_count = 0, err_count = 0;
  int          en_cyc = 0, last_rx_cyc = 0;
  int          spi_len = 6;
  txn_t        exp_txn[$];
  logic [7:0]  exp_bytes[$];
  logic [7:0]  uart_log[$];
  logic [31:0] model_div = 32'd1;
  txn_t        mon_t;
  logic [7:0]  mon_b;
  logic [31:0] div_prev = 32'd1;
  logic        rst_prev = 1'b1;
  logic [31:0] spi_addr;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] spi_resp(input logic [31:0] a);
    if (a == 32'd3) return 16'hBEEF;
    return {8'h5A, a[7:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every enable and every UART strobe is matched in arrival order.
  always @(negedge clk) begin
    if (enable) begin
      en_count++;
      en_cyc = cyc;
      if (exp_txn.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_enable addr=%0h required=no transaction", addr);
      end else begin
        mon_t = exp_txn.pop_front();
        check("txn_addr", 64'(addr), 64'(mon_t.addr));
        check("txn_tx_data", 64'(tx_data), 64'(mon_t.data));
        check("txn_rw", 64'(rw), 64'(mon_t.rw));
        check("txn_clk_div", 64'(clk_div), 64'(mon_t.div));
      end
    end
    if (tx_uart_start) begin
      start_count++;
      uart_log.push_back(tx_uart_data);
      if (exp_bytes.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_uart_tx byte=%0h required=no byte", tx_uart_data);
      end else begin
        mon_b = exp_bytes.pop_front();
        check("uart_byte", 64'(tx_uart_data), 64'(mon_b));
      end
    end
    if (frame_err) err_count++;
    if (busy && !reset && !rst_prev) check("clk_div_stable_while_busy", 64'(clk_div), 64'(div_prev));
    div_prev = clk_div;
    rst_prev = reset;
  end

  // SPI master model: busy rises two cycles after enable, read word valid as busy falls.
  initial forever begin
    @(negedge clk);
    if (enable) begin
      spi_addr = addr;
      repeat (2) @(negedge clk);
      model_busy = 1'b1;
      repeat (spi_len) @(negedge clk);
      spi_rx_data = spi_resp(spi_addr);
      model_busy = 1'b0;
    end
  end

  // UART TX model: busy for a few cycles after each start strobe.
  initial forever begin
    @(negedge clk);
    if (tx_uart_start) begin
      @(negedge clk);
      tx_uart_busy = 1'b1;
      repeat (3) @(negedge clk);
      tx_uart_busy = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_uart_data = b;
    rx_ready     = 1'b1;
    last_rx_cyc  = cyc;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [DW-1:0] data, input bit drop);
    txn_t          t;
    logic [DW-1:0] r;
    if (!drop) begin
      if (hdr[6]) begin
        model_div = 32'(data);
      end else begin
        t.addr = {26'b0, hdr[5:0]};
        t.data = data;
        t.rw   = hdr[7];
        t.div  = model_div;
        exp_txn.push_back(t);
        if (hdr[7]) begin
          r = spi_resp(t.addr);
          exp_bytes.push_back(r[15:8]);
          exp_bytes.push_back(r[7:0]);
        end
      end
    end
    send_byte(hdr);
    send_byte(data[15:8]);
    send_byte(data[7:0]);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_txn.size() != 0 || exp_bytes.size() != 0 || busy || tx_uart_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL %s_drain pending_txn=%0d pending_bytes=%0d required=0", name, exp_txn.size(), exp_bytes.size());
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog time_limit_reached required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int e0, s0, r0, n;
    repeat (3) @(negedge clk);
    check("rst_clk_div", 64'(clk_div), 64'd1);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_rw", 64'(rw), 64'd0);
    check("rst_enable", 64'(enable), 64'd0);
    check("rst_tx_uart_start", 64'(tx_uart_start), 64'd0);
    check("rst_tx_uart_data", 64'(tx_uart_data), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_fifo_full", 64'(fifo_full), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single write, with latency from the last payload byte to enable.
    e0 = en_count; s0 = start_count;
    send_frame(8'h05, 16'hF500, 0);
    wait_idle("write");
    check("write_enables", 64'(en_count - e0), 64'd1);
    check("write_addr", 64'(addr), 64'd5);
    check("write_tx_data", 64'(tx_data), 64'hF500);
    check("write_rw", 64'(rw), 64'd0);
    check("write_no_uart", 64'(start_count - s0), 64'd0);
    check("write_latency", 64'(en_cyc - last_rx_cyc), 64'd4);

    // Read returning 0xBEEF over UART, MSB first.
    s0 = start_count; uart_log.delete();
    send_frame(8'h83, 16'h0000, 0);
    wait_idle("read");
    check("read_rw", 64'(rw), 64'd1);
    check("read_addr", 64'(addr), 64'd3);
    check("read_uart_starts", 64'(start_count - s0), 64'd2);
    check("read_uart_count", 64'(uart_log.size()), 64'd2);
    if (uart_log.size() == 2) begin
      check("read_byte0", 64'(uart_log[0]), 64'hBE);
      check("read_byte1", 64'(uart_log[1]), 64'hEF);
    end

    // Config frame between two writes takes effect in order.
    e0 = en_count;
    send_frame(8'h01, 16'h1111, 0);
    send_frame(8'h40, 16'h000A, 0);
    send_frame(8'h02, 16'h2222, 0);
    wait_idle("config");
    check("cfg_enables", 64'(en_count - e0), 64'd2);
    check("cfg_clk_div", 64'(clk_div), 64'd10);
    check("cfg_last_addr", 64'(addr), 64'd2);

    // Partial frame times out; next frame still works.
    e0 = en_count; r0 = err_count;
    send_byte(8'h07);
    send_byte(8'h12);
    repeat (TIMEOUT + 10) @(negedge clk);
    check("timeout_frame_err", 64'(err_count - r0), 64'd1);
    check("timeout_no_enable", 64'(en_count - e0), 64'd0);
    send_frame(8'h08, 16'h3456, 0);
    wait_idle("after_timeout");
    check("after_timeout_enables", 64'(en_count - e0), 64'd1);
    check("after_timeout_addr", 64'(addr), 64'd8);
    check("after_timeout_data", 64'(tx_data), 64'h3456);

    // Overflow: busy held, five frames into a four-deep queue.
    hold_busy = 1'b1;
    e0 = en_count; r0 = err_count;
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 16'h1000 + 16'(i), i == 4);
    repeat (3) @(negedge clk);
    check("ovf_fifo_full", 64'(fifo_full), 64'd1);
    check("ovf_frame_err", 64'(err_count - r0), 64'd1);
    check("ovf_no_enable_while_busy", 64'(en_count - e0), 64'd0);
    hold_busy = 1'b0;
    wait_idle("overflow");
    check("ovf_enables", 64'(en_count - e0), 64'd4);
    check("ovf_last_addr", 64'(addr), 64'h13);
    check("ovf_fifo_drained", 64'(fifo_full), 64'd0);

    // Reset during a long transaction with two frames queued behind it.
    spi_len = 60;
    send_frame(8'h20, 16'hAAAA, 0);
    n = 0;
    while (!model_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_busy_seen", 64'(model_busy), 64'd1);
    send_frame(8'h21, 16'hBBBB, 0);
    send_frame(8'h22, 16'hCCCC, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_txn.delete();
    exp_bytes.delete();
    model_div = 32'd1;
    @(negedge clk);
    check("midrst_enable", 64'(enable), 64'd0);
    check("midrst_addr", 64'(addr), 64'd0);
    check("midrst_tx_data", 64'(tx_data), 64'd0);
    check("midrst_rw", 64'(rw), 64'd0);
    check("midrst_clk_div", 64'(clk_div), 64'd1);
    check("midrst_fifo_full", 64'(fifo_full), 64'd0);
    check("midrst_tx_uart_start", 64'(tx_uart_start), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    e0 = en_count;
    n = 0;
    while (model_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midrst_busy_released", 64'(model_busy), 64'd0);
    repeat (40) @(negedge clk);
    check("midrst_no_enable", 64'(en_count - e0), 64'd0);
    spi_len = 6;
    send_frame(8'h09, 16'h0102, 0);
    wait_idle("post_reset");
    check("post_reset_enables", 64'(en_count - e0), 64'd1);
    check("post_reset_addr", 64'(addr), 64'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
